// File: rtl/dpram_stream_reader.sv
// Walks a block-RAM read port from base_addr for length words and streams them out in order.
// Latency: first word valid 3 edges after start is sampled; then one word per clock.
// Backpressure: 2-entry skid buffer absorbs the RAM read latency; issue stalls while full.
module dpram_stream_reader #(
    parameter int addr_width = 8,
    parameter int data_width = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [addr_width:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [addr_width-1:0] ram_addr,
    input  logic [data_width-1:0] ram_q,
    output logic                  m_valid,
    output logic [data_width-1:0] m_data,
    input  logic                  m_ready
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    state_t                state_next;
    logic                  done_next;
    logic [addr_width:0]   remaining;
    logic                  inflight;
    logic [1:0]            entries;
    logic [data_width-1:0] slot0;
    logic [data_width-1:0] slot1;
    logic                  pop;
    logic                  push;
    logic                  issue;
    logic                  finish;
    logic [2:0]            occ;

    assign m_valid = (entries != 2'd0);
    assign m_data  = slot0;
    assign busy    = (state != IDLE);
    assign pop     = m_valid & m_ready;
    // The read issued last edge lands in the buffer at this edge.
    assign push    = inflight;

    // Occupancy after this edge if nothing new is issued; issuing is safe while it stays below 2.
    assign occ   = {1'b0, entries} + {2'b00, inflight} - {2'b00, pop};
    assign issue = (state == RUN) && !abort && (remaining != '0) && (occ < 3'd2);

    // Transfer ends at the edge that empties the buffer with nothing left to fetch.
    assign finish = (remaining == '0) && !inflight &&
                    ((entries == 2'd0) || ((entries == 2'd1) && pop));

    // State register and done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= done_next;
        end
    end

    // Next-state logic; abort overrides everything, including a coincident start.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            done_next = 1'b1;
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    if (finish) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Address walker, read-in-flight tracking and FIFO skid buffer (slot0 is the head).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            entries   <= 2'd0;
            slot0     <= '0;
            slot1     <= '0;
        end else if (abort) begin
            remaining <= '0;
            inflight  <= 1'b0;
            entries   <= 2'd0;
        end else if ((state == IDLE) && start) begin
            ram_addr  <= base_addr;
            remaining <= length;
            inflight  <= 1'b0;
            entries   <= 2'd0;
        end else begin
            inflight <= issue;
            if (issue) begin
                ram_addr  <= ram_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            case ({push, pop})
                2'b10: begin
                    if (entries == 2'd0) begin
                        slot0 <= ram_q;
                    end else begin
                        slot1 <= ram_q;
                    end
                    entries <= entries + 2'd1;
                end
                2'b01: begin
                    slot0   <= slot1;
                    entries <= entries - 2'd1;
                end
                2'b11: begin
                    if (entries == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= ram_q;
                    end else begin
                        slot0 <= ram_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_stream_reader.sv
module tb_dpram_stream_reader;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] ram_addr;
    logic [7:0] ram_q;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [256];

    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        logic [7:0] pat;       // m_ready per cycle, bit (edge % 8)
        int         inj;       // cycle to pulse a stray start (0 = none)
        logic [7:0] exp_first;
        logic [7:0] exp_last;
        logic [7:0] exp_end_addr;
    } vec_t;

    vec_t vecs [6];

    dpram_stream_reader #(.addr_width(8), .data_width(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Registered-read RAM port model.
    always @(posedge clock) ram_q <= mem[ram_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got hang, required finish)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int         edges;
        int         npop;
        int         ndone;
        int         first_edge;
        int         stable_err;
        int         ent_err;
        logic       stalled;
        logic [7:0] held;
        @(negedge clock);
        base_addr = v.base;
        length    = v.len;
        start     = 1'b1;
        m_ready   = 1'b0;
        @(negedge clock);
        start = 1'b0;
        edges = 1;
        check("start_addr", ram_addr, v.base);
        check("start_busy", busy, 1);
        npop = 0; ndone = 0; first_edge = 0; stable_err = 0; ent_err = 0;
        stalled = 1'b0; held = '0;
        while (edges < 2000 && !(npop == int'(v.len) && !busy)) begin
            if (m_valid && first_edge == 0) first_edge = edges;
            if (stalled && (m_valid !== 1'b1 || m_data !== held)) stable_err++;
            if (done) ndone++;
            if (dut.entries > 2'd2) ent_err++;
            if (edges == v.inj) begin
                start = 1'b1; base_addr = 8'h80; length = 9'd9;
            end else begin
                start = 1'b0; base_addr = v.base; length = v.len;
            end
            m_ready = v.pat[edges % 8];
            if (m_valid && m_ready) begin
                check("word", m_data, mem[8'(int'(v.base) + npop)]);
                if (npop == 0) check("first_word", m_data, v.exp_first);
                if (npop == int'(v.len) - 1) check("last_word", m_data, v.exp_last);
                npop++;
            end
            stalled = m_valid && !m_ready;
            held    = m_data;
            @(negedge clock);
            edges++;
        end
        start   = 1'b0;
        m_ready = 1'b0;
        check("no_timeout", edges < 2000, 1);
        check("first_valid_edge", first_edge, 3);
        check("word_count", npop, v.len);
        check("stable_stall", stable_err, 0);
        check("entries_le2", ent_err, 0);
        check("early_done", ndone, 0);
        check("done_pulse", done, 1);
        check("busy_after", busy, 0);
        check("valid_after", m_valid, 0);
        check("end_addr", ram_addr, v.exp_end_addr);
        @(negedge clock);
        check("done_single", done, 0);
    endtask

    initial begin
        int pops;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
        mem[8'h10] = 8'hA0; mem[8'h11] = 8'hA1; mem[8'h12] = 8'hA2; mem[8'h13] = 8'hA3;
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;

        //          base    len      pat     inj  first  last   end_addr
        vecs[0] = '{8'h10, 9'd4,   8'hFF, 0, 8'hA0, 8'hA3, 8'h14};  // basic
        vecs[1] = '{8'h10, 9'd4,   8'hA9, 0, 8'hA0, 8'hA3, 8'h14};  // ready 1,0,0,1,0,1,0,1
        vecs[2] = '{8'hFE, 9'd4,   8'hFF, 0, 8'h11, 8'h44, 8'h02};  // wrap
        vecs[3] = '{8'h00, 9'd256, 8'hFF, 0, 8'h33, 8'h22, 8'h00};  // full range
        vecs[4] = '{8'h80, 9'd9,   8'h33, 0, 8'h43, 8'h4B, 8'h89};  // bursty stalls
        vecs[5] = '{8'h10, 9'd4,   8'hFF, 4, 8'hA0, 8'hA3, 8'h14};  // start while busy

        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0; m_ready = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_addr", ram_addr, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

        // length = 0: done next cycle, never busy, no data
        @(negedge clock);
        base_addr = 8'h40; length = 9'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_valid", m_valid, 0);
        @(negedge clock);
        check("len0_done_single", done, 0);
        check("len0_busy_after", busy, 0);

        // abort after 2 pops while stalled; a coincident start must be ignored
        base_addr = 8'h20; length = 9'd8; start = 1'b1; m_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        pops = 0;
        for (int k = 0; k < 20 && pops < 2; k++) begin
            if (m_valid && m_ready) begin
                check("abort_word", m_data, mem[8'(8'h20 + pops)]);
                pops++;
            end
            @(negedge clock);
        end
        m_ready = 1'b0;
        check("abort_pops", pops, 2);
        repeat (3) @(negedge clock);
        check("abort_pre_valid", m_valid, 1);
        check("abort_pre_data", m_data, mem[8'h22]);
        abort = 1'b1; start = 1'b1; base_addr = 8'h40; length = 9'd3;
        @(negedge clock);
        abort = 1'b0; start = 1'b0;
        check("abort_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clock);
        check("abort_done_late", done, 0);
        check("abort_busy_late", busy, 0);
        run_xfer(vecs[0]);

        // asynchronous reset mid-transfer
        @(negedge clock);
        base_addr = 8'h30; length = 9'd8; start = 1'b1; m_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("mid_valid_before", m_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_addr", ram_addr, 0);
        check("mid_rst_done", done, 0);
        @(negedge clock);
        reset = 1'b0; m_ready = 1'b0;
        check("mid_rst_done_after", done, 0);
        run_xfer(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
